seven_segment_controller: RTL and testbench

//  Time-multiplexed driver for the 8-digit, low-asserted seven-segment display.

---
 rtl/ssd_pkg.sv | 36 +++
 rtl/seven_segment_controller_refresh_timer.sv | 41 ++++
 rtl/seven_segment_controller.sv | 144 ++++++++++++++
 tb/tb_seven_segment_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display controller.
//   NUM_DIGITS  number of multiplexed digits
//   SEG_BLANK   segment pattern with every segment off (low-asserted)
//   hex_to_seg  nibble -> low-asserted segment pattern, [6]=A .. [0]=G
//   digit_idx_t index of the digit currently driven
package ssd_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [2:0] digit_idx_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h01;
            4'h1: seg = 7'h4F;
            4'h2: seg = 7'h12;
            4'h3: seg = 7'h06;
            4'h4: seg = 7'h4C;
            4'h5: seg = 7'h24;
            4'h6: seg = 7'h20;
            4'h7: seg = 7'h0F;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h04;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h60;
            4'hC: seg = 7'h31;
            4'hD: seg = 7'h42;
            4'hE: seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_segment_controller_refresh_timer.sv
// Refresh timer: holds each digit for DIGIT_CLOCKS clocks and steps 0..7.
//   clk, rst     clock, asynchronous active-high reset
//   digit_idx    digit currently being refreshed
//   frame_done   registered pulse, high during the last clock of digit 7
module seven_segment_refresh_timer
    import ssd_pkg::*;
#(
    parameter int DIGIT_CLOCKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] digit_idx,
    output logic       frame_done
);

    localparam int TICK_W = (DIGIT_CLOCKS > 2) ? $clog2(DIGIT_CLOCKS) : 1;

    logic [TICK_W-1:0] tick;
    logic              tc;

    assign tc = (tick == TICK_W'(DIGIT_CLOCKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick       <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            // Registered alongside the output stage, so the pulse lines up
            // with the final anode-7 cycle seen on the pins.
            frame_done <= tc && (digit_idx == digit_idx_t'(NUM_DIGITS - 1));
            if (tc) begin
                tick      <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/seven_segment_controller.sv
// Time-multiplexed driver for an 8-digit low-asserted seven-segment display.
//   clk, rst     clock, asynchronous active-high reset
//   display_val  nibble i shown on digit i (digit 0 rightmost)
//   dp_in        per-digit decimal point request
//   blank        per-digit blanking (anode still cycles)
//   load         1-cycle strobe capturing display_val/dp_in/blank
//   segments     low-asserted segments, [6]=A .. [0]=G
//   dp           low-asserted decimal point
//   anode        low-asserted digit enables
//   frame_done   pulse on the last clock of digit 7
// Build option: SSD_LEADING_ZERO_BLANK_EN auto-blanks leading zero digits
// (digit 0 is never auto-blanked).
module seven_segment_controller
    import ssd_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int REFRESH_RATE  = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] display_val,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank,
    input  logic        load,
    output logic [6:0]  segments,
    output logic        dp,
    output logic [7:0]  anode,
    output logic        frame_done
);

    localparam int DIGIT_CLOCKS = CLK_FREQUENCY / REFRESH_RATE / NUM_DIGITS;

    generate
        if (DIGIT_CLOCKS < 2) begin : g_bad_rate
            $error("seven_segment_controller: DIGIT_CLOCKS must be at least 2");
        end
    endgenerate

    logic [2:0]  digit_idx;

    logic [31:0] active_val, pend_val, val_nxt;
    logic [7:0]  active_dp, pend_dp, dp_nxt;
    logic [7:0]  active_blank, pend_blank, blank_nxt;
    logic        loaded, loaded_nxt;
    logic        pend_valid;

    logic [7:0]  auto_blank;
    logic [3:0]  nib;
    logic        dark;
    logic [6:0]  seg_d;
    logic        dp_d;

    seven_segment_refresh_timer #(
        .DIGIT_CLOCKS(DIGIT_CLOCKS)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    // The frame_done cycle is the frame boundary: the edge that ends it also
    // launches digit 0, so the swap to new contents lands exactly there.
    // The output stage reads the post-swap values so digit 0 already shows them.
    always_comb begin
        val_nxt    = active_val;
        dp_nxt     = active_dp;
        blank_nxt  = active_blank;
        loaded_nxt = loaded;
        if (frame_done && load) begin
            val_nxt    = display_val;
            dp_nxt     = dp_in;
            blank_nxt  = blank;
            loaded_nxt = 1'b1;
        end else if (frame_done && pend_valid) begin
            val_nxt    = pend_val;
            dp_nxt     = pend_dp;
            blank_nxt  = pend_blank;
            loaded_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
        end else if (load && !frame_done) begin
            pend_val   <= display_val;
            pend_dp    <= dp_in;
            pend_blank <= blank;
            pend_valid <= 1'b1;
        end else if (frame_done) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_val   <= '0;
            active_dp    <= '0;
            active_blank <= '0;
            loaded       <= 1'b0;
        end else begin
            active_val   <= val_nxt;
            active_dp    <= dp_nxt;
            active_blank <= blank_nxt;
            loaded       <= loaded_nxt;
        end
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    always_comb begin
        auto_blank = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            auto_blank[i] = ((val_nxt >> (4 * i)) == 32'd0);
        end
    end
`else
    assign auto_blank = '0;
`endif

    always_comb begin
        nib   = val_nxt[{digit_idx, 2'b00} +: 4];
        // Nothing is lit until the first contents reach the active registers.
        dark  = !loaded_nxt || blank_nxt[digit_idx] || auto_blank[digit_idx];
        seg_d = dark ? SEG_BLANK : hex_to_seg(nib);
        dp_d  = dark || !dp_nxt[digit_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode    <= 8'hFF;
            segments <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            anode    <= ~(8'b1 << digit_idx);
            segments <= seg_d;
            dp       <= dp_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_controller.sv
module tb_seven_segment_controller;

    localparam int DC = 125;
    localparam int FRAME = 8 * DC;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] display_val;
    logic [7:0]  dp_in;
    logic [7:0]  blank;
    logic        load;
    logic [6:0]  segments;
    logic        dp;
    logic [7:0]  anode;
    logic        frame_done;

    seven_segment_controller #(
        .CLK_FREQUENCY(1_000_000),
        .REFRESH_RATE (1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .display_val (display_val),
        .dp_in       (dp_in),
        .blank       (blank),
        .load        (load),
        .segments    (segments),
        .dp          (dp),
        .anode       (anode),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] val;
        logic [7:0]  dpi;
        logic [7:0]  blk;
        logic        loaded;
    } disp_t;

    typedef struct packed {
        disp_t cur;
        int    pos_a;
        disp_t a;
        int    pos_b;
        disp_t b;
    } frame_vec_t;

    logic [6:0] seg_tbl [16];
    frame_vec_t fv [7];
    int n_checks = 0;
    int n_fail   = 0;
    int frame_no = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic is_dark(input disp_t s, input int d);
        return !s.loaded || s.blk[d] || (LZ && d > 0 && ((s.val >> (4 * d)) == 32'd0));
    endfunction

    function automatic logic [6:0] exp_seg(input disp_t s, input int d);
        logic [31:0] v;
        v = s.val >> (4 * d);
        return is_dark(s, d) ? 7'h7F : seg_tbl[v[3:0]];
    endfunction

    function automatic logic exp_dp(input disp_t s, input int d);
        return is_dark(s, d) ? 1'b1 : ~s.dpi[d];
    endfunction

    task automatic apply(input disp_t s);
        display_val = s.val;
        dp_in       = s.dpi;
        blank       = s.blk;
        load        = 1'b1;
    endtask

    // Entered just after a negedge whose following posedge starts digit 0.
    // Observes one whole frame and optionally strobes load at given positions.
    task automatic run_frame(input frame_vec_t v);
        int anode_ok [8];
        int seg_bad  [8];
        int dp_bad   [8];
        logic [6:0] seg_seen [8];
        int fd_bad;
        int pos;
        fd_bad = 0;
        for (int d = 0; d < 8; d++) begin
            anode_ok[d] = 0; seg_bad[d] = 0; dp_bad[d] = 0; seg_seen[d] = 7'h0;
        end
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < DC; c++) begin
                @(negedge clk);
                load = 1'b0;
                pos = d * DC + c;
                if (anode === ~(8'b1 << d)) anode_ok[d]++;
                if (segments !== exp_seg(v.cur, d)) begin
                    seg_bad[d]++;
                    seg_seen[d] = segments;
                end
                if (dp !== exp_dp(v.cur, d)) dp_bad[d]++;
                if (frame_done !== (d == 7 && c == DC - 1)) fd_bad++;
                if (pos == v.pos_a) apply(v.a);
                if (pos == v.pos_b) apply(v.b);
            end
        end
        for (int d = 0; d < 8; d++) begin
            check($sformatf("frame%0d anode_d%0d low cycles", frame_no, d), 64'(anode_ok[d]), 64'(DC));
            check($sformatf("frame%0d seg_d%0d want %h seen %h bad cycles", frame_no, d,
                            exp_seg(v.cur, d), seg_seen[d]), 64'(seg_bad[d]), 64'd0);
            check($sformatf("frame%0d dp_d%0d want %b bad cycles", frame_no, d, exp_dp(v.cur, d)),
                  64'(dp_bad[d]), 64'd0);
        end
        check($sformatf("frame%0d frame_done misplaced cycles", frame_no), 64'(fd_bad), 64'd0);
        frame_no++;
    endtask

    initial begin
        disp_t none_d, v_abcd, v_blk, v_ones, v_dead, v_0f, v_a0, v_zero;
        bit found;

        seg_tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

        none_d = '{val: 32'h0,        dpi: 8'h00, blk: 8'h00, loaded: 1'b0};
        v_abcd = '{val: 32'h1234ABCD, dpi: 8'h01, blk: 8'h00, loaded: 1'b1};
        v_blk  = '{val: 32'h87654321, dpi: 8'h00, blk: 8'hF0, loaded: 1'b1};
        v_ones = '{val: 32'h11111111, dpi: 8'hFF, blk: 8'h00, loaded: 1'b1};
        v_dead = '{val: 32'hDEADBEEF, dpi: 8'h00, blk: 8'h00, loaded: 1'b1};
        v_0f   = '{val: 32'h0F0F0F0F, dpi: 8'hAA, blk: 8'h00, loaded: 1'b1};
        v_a0   = '{val: 32'h000000A0, dpi: 8'h00, blk: 8'h00, loaded: 1'b1};
        v_zero = '{val: 32'h00000000, dpi: 8'h00, blk: 8'h00, loaded: 1'b1};

        // cur = what this frame must show; loads land mid-frame, or in the
        // frame_done cycle (pos FRAME-1) to exercise the bypass.
        fv[0] = '{cur: none_d, pos_a: 500,       a: v_abcd, pos_b: -1,  b: none_d};
        fv[1] = '{cur: v_abcd, pos_a: 500,       a: v_blk,  pos_b: -1,  b: none_d};
        fv[2] = '{cur: v_blk,  pos_a: 500,       a: v_ones, pos_b: 501, b: v_dead};
        fv[3] = '{cur: v_dead, pos_a: FRAME - 1, a: v_0f,   pos_b: -1,  b: none_d};
        fv[4] = '{cur: v_0f,   pos_a: 10,        a: v_a0,   pos_b: -1,  b: none_d};
        fv[5] = '{cur: v_a0,   pos_a: FRAME - 1, a: v_zero, pos_b: -1,  b: none_d};
        fv[6] = '{cur: v_zero, pos_a: -1,        a: none_d, pos_b: -1,  b: none_d};

        rst = 1'b1;
        display_val = 32'h0;
        dp_in = 8'h0;
        blank = 8'h0;
        load = 1'b0;
        repeat (3) @(negedge clk);
        check("reset anode", 64'(anode), 64'hFF);
        check("reset segments", 64'(segments), 64'h7F);
        check("reset dp", 64'(dp), 64'h1);
        check("reset frame_done", 64'(frame_done), 64'h0);

        rst = 1'b0;
        for (int i = 0; i < 7; i++) run_frame(fv[i]);

        // Asynchronous reset in the middle of digit 3.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            if (anode === 8'hF7) found = 1'b1;
        end
        check("reach digit 3 within budget", 64'(found), 64'h1);
        repeat (40) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst anode", 64'(anode), 64'hFF);
        check("async rst segments", 64'(segments), 64'h7F);
        check("async rst dp", 64'(dp), 64'h1);
        check("async rst frame_done", 64'(frame_done), 64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_frame('{cur: none_d, pos_a: -1, a: none_d, pos_b: -1, b: none_d});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(20 * FRAME * 10);
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
